bsg_manycore_link_sif_drain: RTL and testbench
==============================================

# bsg_manycore_link_sif_drain

Quiesce and outstanding-request tracker on one manycore link, sitting between the manycore mesh edge and the subpod SDR link converter's core-side link_sif. It counts request packets leaving the mesh through the link and the return packets coming back. On request it stops admitting new outbound requests and reports drained once every outstanding return has arrived. The SDR link can then be disabled or re-tagged without losing traffic.

## Interface
Parameters:
- addr_width_p, none, manycore packet address width
- data_width_p, none, manycore data width
- x_cord_width_p, none, X coordinate width
- y_cord_width_p, none, Y coordinate width
- max_out_p, 32, maximum outstanding outbound requests; must be ≥1

Ports (link_sif width is `bsg_manycore_link_sif_width` of the four parameters):
- clk_i, in, 1, core clock; the only clock
- reset_n_i, in, 1, synchronous, active-low reset
- mesh_link_sif_i, in, link_sif, from mesh: outbound fwd, inbound rev ready
- mesh_link_sif_o, out, link_sif, to mesh: inbound fwd, returning rev, outbound fwd ready
- sdr_link_sif_i, in, link_sif, from SDR converter
- sdr_link_sif_o, out, link_sif, to SDR converter
- drain_req_i, in, 1, level; high requests quiesce, low resumes
- drained_o, out, 1, high when quiesced and outstanding==0
- outstanding_o, out, clog2(max_out_p+1), current outstanding count
- error_o, out, 1, sticky; return received with outstanding==0

## Operation
- Channel transfer: v & ready_and_rev in the same cycle. All four channels use valid/ready_and.
- Passthrough wires: inbound fwd (sdr→mesh), outbound rev (mesh→sdr), returning rev (sdr→mesh). These carry no gating.
- Outbound fwd (mesh→sdr) is gated by allow. allow = (state==RUN) & (outstanding != max_out_p).
  - sdr fwd.v = mesh fwd.v & allow.
  - mesh fwd.ready_and_rev = sdr fwd.ready_and_rev & allow.
  - data passes unmodified.
- allow depends only on registered state. There is no combinational path from drain_req_i to any link output.
- Counter: +1 on an outbound fwd transfer, −1 on a returning rev transfer (sdr→mesh). A simultaneous +1 and −1 leaves the count unchanged.
- Underflow: a −1 while the count is 0 leaves the count at 0 and sets error_o. error_o clears only on reset.
- Saturation: the count cannot exceed max_out_p because allow drops at max.
- FSM states RUN, DRAIN, DRAINED:
  - RUN→DRAIN when drain_req_i=1.
  - DRAIN→DRAINED when drain_req_i=1 and the next count is 0.
  - DRAIN→RUN when drain_req_i=0.
  - DRAINED→RUN when drain_req_i=0.
  - DRAINED stays DRAINED if a stray return arrives; error_o follows the underflow rule.
- drained_o = (state==DRAINED), registered.
- Mid-operation reset: count and state are cleared. Returns still in flight for pre-reset requests then count as underflow. The system must assert reset on both the mesh and the SDR side together.

## Timing
- Reset values: state=RUN, outstanding_o=0, drained_o=0, error_o=0. Passthrough outputs follow their inputs during reset. Outbound fwd is open during reset because state=RUN and count=0.
- drain_req_i rising at cycle t:
  - an outbound transfer in cycle t is still accepted and counted;
  - allow=0 from t+1.
- drained_o rises one cycle after the cycle in which the last return transfers (registered next-count check). It also rises at t+1 if the count was already 0 at t.
- drain_req_i falling at cycle t: drained_o=0 and allow restored at t+1.
- outstanding_o is the registered count; it reflects a transfer one cycle after it occurs.

## Structure
- Add the state enum `bsg_manycore_link_drain_state_e` to bsg_manycore_pkg. The link_sif struct comes from the existing declare_bsg_manycore_link_sif_s macro.
- Sub-module: bsg_counter_up_down for the count (max_val_p=max_out_p, init 0, up/down of 1). Reset it from ~reset_n_i.
- FSM, allow logic and sticky error stay in this module.

## Test plan
- Reset, then 5 outbound requests, then 5 returns → outstanding_o reaches 5 and returns to 0; error_o=0; drained_o=0 throughout.
- max_out_p=4, send 6 requests with no returns → 4 accepted; mesh fwd ready_and_rev=0 with v held. One return → exactly one more request accepted; count stays 4.
- Drain with 3 outstanding:
  - drain_req_i=1 → no new fwd transfers from the next cycle; drained_o=0;
  - after the 3rd return → drained_o=1 one cycle later;
  - drain_req_i=0 → traffic resumes next cycle.
- Simultaneous outbound transfer and return at count 2 → count stays 2. drain_req_i rising in the same cycle as a transfer → that transfer is counted (count 3).
- Return with count 0 → error_o=1 sticky, count 0; reset_n_i=0 for one cycle → error_o=0.
- Inbound fwd and outbound rev random traffic while DRAINED → passed unmodified with zero latency; drained_o remains 1.

Source files
------------

// File: rtl/bsg_manycore_pkg.sv
// Shared manycore link definitions: drain FSM state encoding and the packet
// and link_sif width helpers used to size flat link_sif ports.
package bsg_manycore_pkg;

  typedef enum logic [1:0] {
    eLinkDrainRun     = 2'd0,
    eLinkDrainDrain   = 2'd1,
    eLinkDrainDrained = 2'd2
  } bsg_manycore_link_drain_state_e;

  localparam int bsg_manycore_reg_id_width_gp   = 5;
  localparam int bsg_manycore_op_width_gp       = 2;
  localparam int bsg_manycore_ret_type_width_gp = 2;

  // Request packet: addr, data, byte mask, opcode, reg id, src and dst coords.
  function automatic int bsg_manycore_packet_width(input int addr_w, input int data_w,
                                                   input int x_w, input int y_w);
    return addr_w + data_w + (data_w / 8) + bsg_manycore_op_width_gp
         + bsg_manycore_reg_id_width_gp + 2 * (x_w + y_w);
  endfunction

  // Return packet: data, reg id, return type, destination coords.
  function automatic int bsg_manycore_return_packet_width(input int data_w,
                                                          input int x_w, input int y_w);
    return data_w + bsg_manycore_reg_id_width_gp + bsg_manycore_ret_type_width_gp + x_w + y_w;
  endfunction

  // link_sif = {fwd {v, packet, ready_and_rev}, rev {v, return packet, ready_and_rev}}.
  function automatic int bsg_manycore_link_sif_width(input int addr_w, input int data_w,
                                                     input int x_w, input int y_w);
    return bsg_manycore_packet_width(addr_w, data_w, x_w, y_w)
         + bsg_manycore_return_packet_width(data_w, x_w, y_w) + 4;
  endfunction

endpackage

// File: rtl/bsg_counter_up_down.sv
// Up/down counter with synchronous active-high reset; caller guarantees the
// count stays within 0..max_val_p.
module bsg_counter_up_down #(
  parameter int max_val_p  = 32,
  parameter int init_val_p = 0,
  parameter int max_step_p = 1,
  localparam int width_lp  = $clog2(max_val_p + 1),
  localparam int step_w_lp = $clog2(max_step_p + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [step_w_lp-1:0] up_i,
  input  logic [step_w_lp-1:0] down_i,
  output logic [width_lp-1:0]  count_o
);

  // Apply the net step each cycle; reset loads the initial value.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_o <= width_lp'(init_val_p);
    end else begin
      count_o <= count_o + width_lp'(up_i) - width_lp'(down_i);
    end
  end

endmodule

// File: rtl/bsg_manycore_link_sif_drain.sv
// Quiesce / outstanding-request tracker on one manycore link between the mesh
// edge and the SDR link converter. Outbound requests are gated by a registered
// allow; all other channels pass straight through.
module bsg_manycore_link_sif_drain
  import bsg_manycore_pkg::*;
#(
  parameter int addr_width_p   = 28,
  parameter int data_width_p   = 32,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int max_out_p      = 32,
  localparam int link_sif_width_lp =
    bsg_manycore_link_sif_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p),
  localparam int cnt_w_lp = $clog2(max_out_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [link_sif_width_lp-1:0] mesh_link_sif_i,
  output logic [link_sif_width_lp-1:0] mesh_link_sif_o,
  input  logic [link_sif_width_lp-1:0] sdr_link_sif_i,
  output logic [link_sif_width_lp-1:0] sdr_link_sif_o,
  input  logic                         drain_req_i,
  output logic                         drained_o,
  output logic [cnt_w_lp-1:0]          outstanding_o,
  output logic                         error_o
);

  localparam int fwd_w_lp =
    bsg_manycore_packet_width(addr_width_p, data_width_p, x_cord_width_p, y_cord_width_p);
  localparam int rev_w_lp =
    bsg_manycore_return_packet_width(data_width_p, x_cord_width_p, y_cord_width_p);
  localparam logic [cnt_w_lp-1:0] max_cnt_lp = cnt_w_lp'(max_out_p);

  typedef struct packed {
    logic                v;
    logic [fwd_w_lp-1:0] data;
    logic                ready_and_rev;
  } link_fwd_s;

  typedef struct packed {
    logic                v;
    logic [rev_w_lp-1:0] data;
    logic                ready_and_rev;
  } link_rev_s;

  typedef struct packed {
    link_fwd_s fwd;
    link_rev_s rev;
  } link_sif_s;

  link_sif_s w_mesh_i, w_mesh_o, w_sdr_i, w_sdr_o;

  bsg_manycore_link_drain_state_e r_state;
  logic                r_drained;
  logic                r_error;
  logic [cnt_w_lp-1:0] w_count;
  logic [cnt_w_lp-1:0] w_count_next;
  logic                w_allow;
  logic                w_up;
  logic                w_ret;
  logic                w_down;
  logic                w_cnt_zero;
  logic                w_next_zero;

  assign w_mesh_i = mesh_link_sif_i;
  assign w_sdr_i  = sdr_link_sif_i;
  assign mesh_link_sif_o = w_mesh_o;
  assign sdr_link_sif_o  = w_sdr_o;

  // allow is built only from registered state so drain_req_i never reaches a link output.
  assign w_allow = (r_state == eLinkDrainRun) & (w_count != max_cnt_lp);

  // Outbound requests (mesh -> sdr), gated.
  assign w_sdr_o.fwd.v               = w_mesh_i.fwd.v & w_allow;
  assign w_sdr_o.fwd.data            = w_mesh_i.fwd.data;
  assign w_mesh_o.fwd.ready_and_rev  = w_sdr_i.fwd.ready_and_rev & w_allow;

  // Inbound requests (sdr -> mesh), ungated.
  assign w_mesh_o.fwd.v              = w_sdr_i.fwd.v;
  assign w_mesh_o.fwd.data           = w_sdr_i.fwd.data;
  assign w_sdr_o.fwd.ready_and_rev   = w_mesh_i.fwd.ready_and_rev;

  // Outbound returns (mesh -> sdr), ungated.
  assign w_sdr_o.rev.v               = w_mesh_i.rev.v;
  assign w_sdr_o.rev.data            = w_mesh_i.rev.data;
  assign w_mesh_o.rev.ready_and_rev  = w_sdr_i.rev.ready_and_rev;

  // Returns for our outbound requests (sdr -> mesh), ungated.
  assign w_mesh_o.rev.v              = w_sdr_i.rev.v;
  assign w_mesh_o.rev.data           = w_sdr_i.rev.data;
  assign w_sdr_o.rev.ready_and_rev   = w_mesh_i.rev.ready_and_rev;

  // A return arriving with nothing outstanding is a stray: flagged, not counted.
  assign w_up         = w_mesh_i.fwd.v & w_sdr_i.fwd.ready_and_rev & w_allow;
  assign w_ret        = w_sdr_i.rev.v & w_mesh_i.rev.ready_and_rev;
  assign w_cnt_zero   = (w_count == '0);
  assign w_down       = w_ret & ~w_cnt_zero;
  assign w_count_next = w_count + cnt_w_lp'(w_up) - cnt_w_lp'(w_down);
  assign w_next_zero  = (w_count_next == '0);

  bsg_counter_up_down #(
    .max_val_p  (max_out_p),
    .init_val_p (0),
    .max_step_p (1)
  ) counter (
    .clk_i   (clk_i),
    .reset_i (~reset_n_i),
    .up_i    (w_up),
    .down_i  (w_down),
    .count_o (w_count)
  );

  assign outstanding_o = w_count;
  assign drained_o     = r_drained;
  assign error_o       = r_error;

  // Drain FSM with registered drained flag and sticky underflow error.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state   <= eLinkDrainRun;
      r_drained <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_error <= r_error | (w_ret & w_cnt_zero);
      case (r_state)
        eLinkDrainRun: begin
          if (drain_req_i) begin
            if (w_next_zero) begin
              r_state   <= eLinkDrainDrained;
              r_drained <= 1'b1;
            end else begin
              r_state   <= eLinkDrainDrain;
            end
          end
        end
        eLinkDrainDrain: begin
          if (!drain_req_i) begin
            r_state <= eLinkDrainRun;
          end else if (w_next_zero) begin
            r_state   <= eLinkDrainDrained;
            r_drained <= 1'b1;
          end
        end
        eLinkDrainDrained: begin
          if (!drain_req_i) begin
            r_state   <= eLinkDrainRun;
            r_drained <= 1'b0;
          end
        end
        default: begin
          r_state   <= eLinkDrainRun;
          r_drained <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_manycore_link_sif_drain.sv
// Bench for bsg_manycore_link_sif_drain: two instances (max_out_p 8 and 4)
// share one stimulus stream; a quiesce model predicts every output each cycle.
module tb_bsg_manycore_link_sif_drain;
  import bsg_manycore_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int XW = 4;
  localparam int YW = 3;
  localparam int FW = bsg_manycore_packet_width(AW, DW, XW, YW);
  localparam int RW = bsg_manycore_return_packet_width(DW, XW, YW);
  localparam int LW = bsg_manycore_link_sif_width(AW, DW, XW, YW);

  typedef struct packed {
    logic          v;
    logic [FW-1:0] data;
    logic          ready_and_rev;
  } fwd_s;
  typedef struct packed {
    logic          v;
    logic [RW-1:0] data;
    logic          ready_and_rev;
  } rev_s;
  typedef struct packed {
    fwd_s fwd;
    rev_s rev;
  } sif_s;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drain_req = 1'b0;
  logic [LW-1:0] mesh_i = '0;
  logic [LW-1:0] sdr_i = '0;

  logic [LW-1:0] mesh_o_a, sdr_o_a, mesh_o_b, sdr_o_b;
  logic          drained_a, drained_b, err_a, err_b;
  logic [3:0]    outs_a;
  logic [2:0]    outs_b;

  int checks = 0;
  int errors = 0;

  // model: outstanding count and sticky error per instance, plus last drain_req
  int cnt [2];
  bit err [2];
  bit pdr;
  int maxv [2];

  always #5 clk = ~clk;

  bsg_manycore_link_sif_drain #(
    .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .max_out_p(8)
  ) dut_a (
    .clk_i(clk), .reset_n_i(rst_n),
    .mesh_link_sif_i(mesh_i), .mesh_link_sif_o(mesh_o_a),
    .sdr_link_sif_i(sdr_i), .sdr_link_sif_o(sdr_o_a),
    .drain_req_i(drain_req), .drained_o(drained_a),
    .outstanding_o(outs_a), .error_o(err_a)
  );

  bsg_manycore_link_sif_drain #(
    .addr_width_p(AW), .data_width_p(DW), .x_cord_width_p(XW), .y_cord_width_p(YW),
    .max_out_p(4)
  ) dut_b (
    .clk_i(clk), .reset_n_i(rst_n),
    .mesh_link_sif_i(mesh_i), .mesh_link_sif_o(mesh_o_b),
    .sdr_link_sif_i(sdr_i), .sdr_link_sif_o(sdr_o_b),
    .drain_req_i(drain_req), .drained_o(drained_b),
    .outstanding_o(outs_b), .error_o(err_b)
  );

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check all outputs against the model, advance the model.
  task automatic step(input bit dr, input bit mfv, input bit sfr, input bit srv,
                      input bit mrr, input bit do_chk);
    sif_s mi, si, emo, eso;
    bit   allow;
    bit   up, ret;
    mi.fwd.v             = mfv;
    mi.fwd.data          = FW'(r128());
    mi.fwd.ready_and_rev = 1'($urandom);
    mi.rev.v             = 1'($urandom);
    mi.rev.data          = RW'(r128());
    mi.rev.ready_and_rev = mrr;
    si.fwd.v             = 1'($urandom);
    si.fwd.data          = FW'(r128());
    si.fwd.ready_and_rev = sfr;
    si.rev.v             = srv;
    si.rev.data          = RW'(r128());
    si.rev.ready_and_rev = 1'($urandom);
    mesh_i    = mi;
    sdr_i     = si;
    drain_req = dr;
    #1;
    if (do_chk) begin
      for (int k = 0; k < 2; k++) begin
        allow = !pdr && (cnt[k] != maxv[k]);
        emo.fwd.v             = si.fwd.v;
        emo.fwd.data          = si.fwd.data;
        emo.fwd.ready_and_rev = sfr && allow;
        emo.rev.v             = srv;
        emo.rev.data          = si.rev.data;
        emo.rev.ready_and_rev = si.rev.ready_and_rev;
        eso.fwd.v             = mfv && allow;
        eso.fwd.data          = mi.fwd.data;
        eso.fwd.ready_and_rev = mi.fwd.ready_and_rev;
        eso.rev.v             = mi.rev.v;
        eso.rev.data          = mi.rev.data;
        eso.rev.ready_and_rev = mrr;
        chk(k == 0 ? "mesh_o_a" : "mesh_o_b", k == 0 ? mesh_o_a : mesh_o_b, emo);
        chk(k == 0 ? "sdr_o_a" : "sdr_o_b", k == 0 ? sdr_o_a : sdr_o_b, eso);
        chk(k == 0 ? "outstanding_a" : "outstanding_b",
            k == 0 ? 128'(outs_a) : 128'(outs_b), 128'(cnt[k]));
        chk(k == 0 ? "drained_a" : "drained_b", k == 0 ? drained_a : drained_b,
            128'(pdr && cnt[k] == 0));
        chk(k == 0 ? "error_a" : "error_b", k == 0 ? err_a : err_b, 128'(err[k]));
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      allow = !pdr && (cnt[k] != maxv[k]);
      up  = mfv && sfr && allow;
      ret = srv && mrr;
      if (!rst_n) begin
        cnt[k] = 0;
        err[k] = 1'b0;
      end else begin
        if (ret && cnt[k] == 0) err[k] = 1'b1;
        cnt[k] = cnt[k] + int'(up) - int'(ret && cnt[k] > 0);
      end
    end
    pdr = rst_n ? dr : 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_pulse(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
    rst_n = 1'b1;
  endtask

  initial begin
    bit dr;
    bit srv;
    maxv[0] = 8;
    maxv[1] = 4;
    cnt[0] = 0; cnt[1] = 0;
    err[0] = 0; err[1] = 0;
    pdr = 0;

    // reset: first cycle has unknown registers, so only later cycles are checked
    rst_n = 1'b0;
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 1, 1, 1, 1);
    rst_n = 1'b1;
    chk("rst_outs_a", outs_a, 0);
    chk("rst_drained_a", drained_a, 0);
    chk("rst_error_a", err_a, 0);

    // 5 requests then 5 returns
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 1);
    chk("req5_outs_a", outs_a, 5);
    chk("req5_outs_b", outs_b, 4);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1, 1);
    chk("ret5_outs_a", outs_a, 0);
    chk("ret5_error_a", err_a, 0);
    chk("ret5_error_b", err_b, 1);
    reset_pulse(1);
    chk("rst_clr_error_b", err_b, 0);

    // saturation
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0, 1);
    chk("sat_outs_b", outs_b, 4);
    chk("sat_outs_a", outs_a, 6);
    step(0, 1, 1, 1, 1, 1);
    chk("sat_ret_outs_b", outs_b, 3);
    chk("sat_simul_outs_a", outs_a, 6);
    step(0, 1, 1, 0, 0, 1);
    chk("sat_one_more_b", outs_b, 4);
    step(0, 1, 1, 0, 0, 1);
    chk("sat_hold_b", outs_b, 4);
    chk("sat_max_a", outs_a, 8);
    step(0, 1, 1, 0, 0, 1);
    chk("sat_hold_a", outs_a, 8);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1, 1);
    chk("sat_drain_outs_a", outs_a, 0);
    reset_pulse(1);

    // drain with 3 outstanding; drain rising together with a transfer
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 1);
    step(1, 1, 1, 0, 0, 1);
    chk("drain_edge_outs_a", outs_a, 3);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 1);
    chk("drain_blocked_outs_a", outs_a, 3);
    chk("drain_wait_drained_a", drained_a, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1, 1);
    chk("drained_a", drained_a, 1);
    chk("drained_b", drained_b, 1);
    step(1, 0, 0, 1, 1, 1);
    chk("stray_error_a", err_a, 1);
    chk("stray_drained_a", drained_a, 1);
    for (int i = 0; i < 10; i++) step(1, 1'($urandom), 1'($urandom), 0, 1'($urandom), 1);
    chk("pass_drained_a", drained_a, 1);
    step(0, 1, 1, 0, 0, 1);
    chk("resume_drained_a", drained_a, 0);
    step(0, 1, 1, 0, 0, 1);
    chk("resume_outs_a", outs_a, 1);
    reset_pulse(1);

    // underflow, sticky until reset
    step(0, 0, 0, 1, 1, 1);
    chk("uf_error_a", err_a, 1);
    chk("uf_outs_a", outs_a, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("uf_sticky_a", err_a, 1);
    reset_pulse(1);
    chk("uf_clr_a", err_a, 0);

    // simultaneous transfer and return at count 2
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 1, 1, 1, 1);
    chk("simul_outs_a", outs_a, 2);
    chk("simul_outs_b", outs_b, 2);

    // randomized traffic with drain toggles and occasional reset
    dr = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) dr = ~dr;
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      srv = 1'($urandom) && cnt[0] > 0 && cnt[1] > 0;
      step(dr, 1'($urandom), 1'($urandom), srv, 1'($urandom), 1);
      rst_n = 1'b1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
